// File: rtl/fifo_word_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : fifo_word_uart_tx
// Purpose  : Pops 32-bit words from the output FIFO and sends each one as four
//            UART bytes (8N1; 8E1 when UART_TX_PARITY_EN is defined).
// Revision : 1.0 - initial release
// ============================================================================
module fifo_word_uart_tx #(
  parameter int CLKS_PER_BIT   = 868,
  parameter int MSB_BYTE_FIRST = 0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        enable,
  input  logic        fifo_empty,
  output logic        fifo_rd_en,
  input  logic [31:0] fifo_rd_data,
  output logic        tx,
  output logic        busy,
  output logic        word_done,
  output logic [1:0]  byte_idx
);

  localparam int c_CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_PRE = c_CNT_W'(CLKS_PER_BIT - 2);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

  localparam logic [2:0] c_S_IDLE   = 3'd0;
  localparam logic [2:0] c_S_LOAD   = 3'd1;
  localparam logic [2:0] c_S_START  = 3'd2;
  localparam logic [2:0] c_S_DATA   = 3'd3;
  localparam logic [2:0] c_S_STOP   = 3'd4;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] c_S_PARITY = 3'd5;
`endif

  logic [2:0]         r_state;
  logic [c_CNT_W-1:0] r_cnt;
  logic [2:0]         r_bit;
  logic [1:0]         r_byte;
  logic [31:0]        r_word;
  logic               r_tx;
  logic               r_busy;
  logic               r_rd_en;
  logic               r_done;

  logic               w_wrap;
  logic               w_pop;
  logic [1:0]         w_sel;
  logic [7:0]         w_byte;
  logic [2:0]         w_bit_nxt;

  assign w_wrap    = (r_cnt == c_CNT_MAX);
  assign w_pop     = enable & ~fifo_empty;
  assign w_sel     = (MSB_BYTE_FIRST != 0) ? ~r_byte : r_byte;
  assign w_byte    = r_word[{w_sel, 3'b000} +: 8];
  assign w_bit_nxt = r_bit + 3'd1;

  // Every output register is loaded with its value for the coming cycle, so
  // the pop decision for the first IDLE cycle is taken on the last STOP edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= c_S_IDLE;
      r_cnt   <= '0;
      r_bit   <= 3'd0;
      r_byte  <= 2'd0;
      r_word  <= 32'd0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_rd_en <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        c_S_IDLE: begin
          r_tx <= 1'b1;
          if (r_rd_en) begin
            r_rd_en <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= c_S_LOAD;
          end else begin
            r_rd_en <= w_pop;
            r_busy  <= w_pop;
          end
        end
        c_S_LOAD: begin
          r_word  <= fifo_rd_data;
          r_byte  <= 2'd0;
          r_cnt   <= '0;
          r_tx    <= 1'b0;
          r_state <= c_S_START;
        end
        c_S_START: begin
          if (w_wrap) begin
            r_cnt   <= '0;
            r_bit   <= 3'd0;
            r_tx    <= w_byte[0];
            r_state <= c_S_DATA;
          end else begin
            r_cnt <= r_cnt + c_CNT_ONE;
          end
        end
        c_S_DATA: begin
          if (w_wrap) begin
            r_cnt <= '0;
            if (r_bit == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              r_tx    <= ^w_byte;
              r_state <= c_S_PARITY;
`else
              r_tx    <= 1'b1;
              r_state <= c_S_STOP;
`endif
            end else begin
              r_bit <= w_bit_nxt;
              r_tx  <= w_byte[w_bit_nxt];
            end
          end else begin
            r_cnt <= r_cnt + c_CNT_ONE;
          end
        end
`ifdef UART_TX_PARITY_EN
        c_S_PARITY: begin
          if (w_wrap) begin
            r_cnt   <= '0;
            r_tx    <= 1'b1;
            r_state <= c_S_STOP;
          end else begin
            r_cnt <= r_cnt + c_CNT_ONE;
          end
        end
`endif
        c_S_STOP: begin
          if (w_wrap) begin
            r_cnt <= '0;
            if (r_byte != 2'd3) begin
              r_byte  <= r_byte + 2'd1;
              r_tx    <= 1'b0;
              r_state <= c_S_START;
            end else begin
              r_byte  <= 2'd0;
              r_state <= c_S_IDLE;
              r_rd_en <= w_pop;
              r_busy  <= w_pop;
            end
          end else begin
            r_cnt  <= r_cnt + c_CNT_ONE;
            r_done <= (r_byte == 2'd3) && (r_cnt == c_CNT_PRE);
          end
        end
        default: begin
          r_state <= c_S_IDLE;
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
          r_rd_en <= 1'b0;
        end
      endcase
    end
  end

  assign fifo_rd_en = r_rd_en;
  assign tx         = r_tx;
  assign busy       = r_busy;
  assign word_done  = r_done;
  assign byte_idx   = r_byte;

endmodule
`default_nettype wire
